reg_alu_result_bank: RTL

- Parametrised successor to the single ALU-result register in the register unit.
- Holds NUM_REGS N-bit registers, each loadable from the ALU result bus.
- Models relay actuation with a programmable settle delay before the write commits.
- Drives the shared data bus from one selected register; the bus is wired-OR, so an unselected bank drives zero.

---
 rtl/relay_reg_pkg.sv | 25 ++
 rtl/relay_settle_timer.sv | 37 +++
 rtl/reg_alu_result_bank.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/relay_reg_pkg.sv
// ---------------------------------------------------------------------------
// relay_reg_pkg
// Shared types and helpers for the relay-timed ALU result register bank.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package relay_reg_pkg;

  localparam int REG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } load_state_t;

  // Index width never collapses to zero bits, even for a single register.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/relay_settle_timer.sv
// ---------------------------------------------------------------------------
// relay_settle_timer
// Loadable down-counter that flags the last cycle of the relay settle window.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module relay_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [3:0] c_load_val = 4'(SETTLE_CYCLES);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (load) begin
      r_count <= c_load_val;
    end else if (en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Terminal count is 1, so the window lasts exactly SETTLE_CYCLES enabled cycles.
  assign done = en && (r_count == 4'd1);

endmodule

`default_nettype wire

// File: rtl/reg_alu_result_bank.sv
// ---------------------------------------------------------------------------
// reg_alu_result_bank
// Bank of ALU result registers with relay-settle write delay and a wired-OR
// read port. Optional per-register zero/sign flags: define ALU_FLAGS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_alu_result_bank
  import relay_reg_pkg::*;
#(
  parameter int N             = REG_WIDTH,
  parameter int NUM_REGS      = 2,
  parameter int SETTLE_CYCLES = 2,
  localparam int IW           = idx_width(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  alu_result,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic          sel,
  input  logic [IW-1:0] sel_idx,
  output logic          busy,
  output logic          load_done,
  output logic          load_overrun,
  output logic [N-1:0]  databus,
  output logic          flag_zero,
  output logic          flag_sign
);

  localparam logic [IW:0] c_num_regs   = (IW + 1)'(NUM_REGS);
  localparam logic        c_has_settle = (SETTLE_CYCLES != 0);

  load_state_t   r_state;
  load_state_t   w_next_state;
  logic          w_accept;
  logic          w_in_range;
  logic          w_commit;
  logic          w_timer_done;
  logic [N-1:0]  r_stage_val;
  logic [IW-1:0] r_stage_idx;
  logic          r_overrun;
  logic [N-1:0]  r_regs [NUM_REGS];

  assign w_in_range = ({1'b0, load_idx} < c_num_regs);
  assign w_commit   = (r_state == COMMIT);

  relay_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_accept && c_has_settle),
    .en    (r_state == SETTLE),
    .done  (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    load_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (load && w_in_range) begin
          w_accept     = 1'b1;
          w_next_state = c_has_settle ? SETTLE : COMMIT;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (w_timer_done) begin
          w_next_state = COMMIT;
        end
      end
      COMMIT: begin
        busy         = 1'b1;
        load_done    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Requests arriving while busy (including the commit cycle) are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_val <= '0;
      r_stage_idx <= '0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_overrun <= load && (r_state != IDLE);
      if (w_accept) begin
        r_stage_val <= alu_result;
        r_stage_idx <= load_idx;
      end
      if (w_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (r_stage_idx == IW'(i)) begin
            r_regs[i] <= r_stage_val;
          end
        end
      end
    end
  end

  assign load_overrun = r_overrun;

`ifdef ALU_FLAGS_EN
  logic r_flag_zero [NUM_REGS];
  logic r_flag_sign [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_flag_zero[i] <= 1'b0;
        r_flag_sign[i] <= 1'b0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_stage_idx == IW'(i)) begin
          r_flag_zero[i] <= (r_stage_val == '0);
          r_flag_sign[i] <= r_stage_val[N-1];
        end
      end
    end
  end
`endif

  // Unmatched or out-of-range selects leave everything at 0 for the OR bus.
  always_comb begin
    databus   = '0;
    flag_zero = 1'b0;
    flag_sign = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel && (sel_idx == IW'(i))) begin
        databus = r_regs[i];
`ifdef ALU_FLAGS_EN
        flag_zero = r_flag_zero[i];
        flag_sign = r_flag_sign[i];
`endif
      end
    end
  end

endmodule

`default_nettype wire
